// File: rtl/aes_pkg.sv
// Shared types, constants and helpers for the AES-128 key-schedule engine.
// Contents: round-count/width constants, FSM state enum, word/key typedefs,
// the AES S-box lookup and the GF(2^8) xtime used to step Rcon.
package aes_pkg;

  localparam int unsigned AES_NUM_ROUNDS = 10;
  localparam int unsigned RK_W           = 128;
  localparam logic [7:0]  RCON_INIT      = 8'h01;

  typedef logic [31:0]     aes_word_t;
  typedef logic [RK_W-1:0] aes_key_t;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    DONE
  } ke_state_e;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] aes_sbox(input logic [7:0] b);
    // Entry b sits (255 - b) bytes up from bit 0; 255 - b == ~b.
    logic [10:0] base;
    base = {~b, 3'b000};
    return SBOX_TABLE[base +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/key_subword.sv
// Combinational AES SubWord: substitutes each of the four bytes of a 32-bit
// word through the forward S-box.
// Ports: in_word_i  - 32-bit word to substitute
//        out_word_o - substituted word, same byte order
module key_subword
  import aes_pkg::*;
(
  input  logic [31:0] in_word_i,
  output logic [31:0] out_word_o
);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign out_word_o[8*i +: 8] = aes_sbox(in_word_i[8*i +: 8]);
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key-schedule engine. Accepts a cipher key on start and
// streams round keys 0..10 over a valid/ready handshake, one per cycle when
// the consumer is always ready, then pulses done for one cycle.
// Ports: clk, rst (sync, active-high)
//        start, key_in          - expansion request / cipher key (sampled in IDLE)
//        busy                   - expansion in progress (start..done inclusive)
//        rk_valid, rk_ready     - round-key handshake
//        rk_out, rk_index       - current round key and its round number
//        done                   - one-cycle pulse after round key 10 is taken
// Optional macro AES_KEYEXP_STORE_EN adds an 11-entry round-key store read via
// rd_idx (input) / rd_key (registered output, 1-cycle latency).
module aes_key_expand
  import aes_pkg::*;
#(
  // Fixed for AES-128; any other value is unsupported.
  parameter int unsigned NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [RK_W-1:0] key_in,
  output logic            busy,
  output logic            rk_valid,
  input  logic            rk_ready,
  output logic [RK_W-1:0] rk_out,
  output logic [3:0]      rk_index,
  output logic            done
`ifdef AES_KEYEXP_STORE_EN
  ,
  input  logic [3:0]      rd_idx,
  output logic [RK_W-1:0] rd_key
`endif
);

  localparam logic [3:0] LastIdx = 4'(NUM_ROUNDS);

  ke_state_e  state_q, state_d;
  aes_key_t   rk_q, rk_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] rcon_q, rcon_d;

  aes_word_t w0, w1, w2, w3;
  aes_word_t rot_w3, sub_w3, t_word;
  aes_word_t n0, n1, n2, n3;
  logic      accept_start;
  logic      handshake;

  assign {w0, w1, w2, w3} = rk_q;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  key_subword u_subword (
    .in_word_i  (rot_w3),
    .out_word_o (sub_w3)
  );

  assign t_word = sub_w3 ^ {rcon_q, 24'h0};
  assign n0     = w0 ^ t_word;
  assign n1     = w1 ^ n0;
  assign n2     = w2 ^ n1;
  assign n3     = w3 ^ n2;

  assign accept_start = (state_q == IDLE) && start;
  assign handshake    = (state_q == EMIT) && rk_ready;

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rk_d    = key_in;
          idx_d   = 4'd0;
          rcon_d  = RCON_INIT;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (idx_q == LastIdx) begin
            state_d = DONE;
          end else begin
            rk_d   = {n0, n1, n2, n3};
            idx_d  = idx_q + 4'd1;
            rcon_d = xtime(rcon_q);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rk_q    <= '0;
      idx_q   <= 4'd0;
      rcon_q  <= RCON_INIT;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign rk_valid = (state_q == EMIT);
  assign done     = (state_q == DONE);
  assign rk_out   = rk_q;
  assign rk_index = idx_q;

`ifdef AES_KEYEXP_STORE_EN
  localparam int unsigned NumEntries = NUM_ROUNDS + 1;

  aes_key_t store_q [NumEntries];
  aes_key_t store_d [NumEntries];
  aes_key_t rd_key_q, rd_key_d;

  always_comb begin
    store_d = store_q;
    if (accept_start) begin
      for (int i = 0; i < NumEntries; i++) begin
        store_d[i] = '0;
      end
    end else if (handshake && (idx_q <= LastIdx)) begin
      store_d[idx_q] = rk_q;
    end
    rd_key_d = (rd_idx <= LastIdx) ? store_q[rd_idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumEntries; i++) begin
        store_q[i] <= '0;
      end
      rd_key_q <= '0;
    end else begin
      store_q  <= store_d;
      rd_key_q <= rd_key_d;
    end
  end

  assign rd_key = rd_key_q;
`else
  // Only the store consumes the start/handshake strobes.
  logic unused_strobes;
  assign unused_strobes = accept_start ^ handshake;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed self-checking bench for aes_key_expand using FIPS-197 vectors.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_index;
  logic         done;
`ifdef AES_KEYEXP_STORE_EN
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
`endif

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic [127:0] exp1 [11];
  logic [7:0]   rcon_exp [10];
  logic [127:0] key1, key2, key2_rk1, key2_rk10;

  aes_key_expand dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_out   (rk_out),
    .rk_index (rk_index),
    .done     (done)
`ifdef AES_KEYEXP_STORE_EN
    ,
    .rd_idx   (rd_idx),
    .rd_key   (rd_key)
`endif
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cmp_cnt++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rk_out !== 128'h0 ||
        rk_index !== 4'd0 || dut.rcon_q !== 8'h01) begin
      err_cnt++;
      $display("FAIL reset: valid=%b busy=%b done=%b out=%h idx=%0d rcon=%h, want 0/0/0/0/0/01",
               rk_valid, busy, done, rk_out, rk_index, dut.rcon_q);
    end
  endtask

  // Full run with rk_ready high: 11 keys on consecutive cycles, then done.
  task automatic test_stream;
    rk_ready = 1'b1;
    key_in   = key1;
    start    = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    key_in = '0;
    for (int i = 0; i <= 10; i++) begin
      cmp_cnt++;
      if (rk_valid !== 1'b1 || rk_index !== 4'(i) || rk_out !== exp1[i] || busy !== 1'b1 ||
          done !== 1'b0) begin
        err_cnt++;
        $display("FAIL stream_rk%0d: valid=%b idx=%0d busy=%b done=%b out=%h, want 1/%0d/1/0 %h",
                 i, rk_valid, rk_index, busy, done, rk_out, i, exp1[i]);
      end
      @(negedge clk);
    end
    cmp_cnt++;
    if (done !== 1'b1 || busy !== 1'b1 || rk_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL stream_done: done=%b busy=%b valid=%b, want 1/1/0", done, busy, rk_valid);
    end
    // A start in the DONE cycle must be dropped.
    key_in = key2;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cmp_cnt++;
    if (done !== 1'b0 || busy !== 1'b0 || rk_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL stream_idle: done=%b busy=%b valid=%b, want 0/0/0", done, busy, rk_valid);
    end
    @(negedge clk);
    cmp_cnt++;
    if (busy !== 1'b0 || rk_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL start_in_done: busy=%b valid=%b, want 0/0", busy, rk_valid);
    end
  endtask

  // Random back-pressure (stalls up to 5 cycles); keys must hold and match.
  task automatic test_stall;
    int e        = 0;
    int stall    = 0;
    bit finished = 1'b0;
    key_in = key1;
    start  = 1'b1;
    rk_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      if (done === 1'b1) begin
        finished = 1'b1;
        cmp_cnt++;
        if (e != 11) begin
          err_cnt++;
          $display("FAIL stall_count: accepted=%0d, want 11", e);
        end
      end else begin
        cmp_cnt++;
        if (e > 10 || rk_valid !== 1'b1 || rk_index !== 4'(e) || rk_out !== exp1[e]) begin
          err_cnt++;
          $display("FAIL stall_rk%0d: valid=%b idx=%0d out=%h", e, rk_valid, rk_index, rk_out);
        end
        if (stall >= 5 || $urandom_range(0, 1) == 1) begin
          rk_ready = 1'b1;
          stall    = 0;
          e++;
        end else begin
          rk_ready = 1'b0;
          stall++;
        end
      end
      @(negedge clk);
    end
    if (!finished) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL stall_timeout: done never seen, accepted=%0d", e);
    end
    rk_ready = 1'b1;
    @(negedge clk);
  endtask

  // start with a different key mid-expansion must be ignored.
  task automatic test_start_ignored;
    rk_ready = 1'b1;
    key_in   = key1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      if (i == 3) begin
        key_in = key2;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      cmp_cnt++;
      if (rk_valid !== 1'b1 || rk_index !== 4'(i) || rk_out !== exp1[i]) begin
        err_cnt++;
        $display("FAIL ignore_rk%0d: valid=%b idx=%0d out=%h, want 1/%0d %h",
                 i, rk_valid, rk_index, rk_out, i, exp1[i]);
      end
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  // Internal Rcon at each round: value used to form the next round key.
  task automatic test_rcon;
    rk_ready = 1'b1;
    key_in   = key1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        cmp_cnt++;
        if (dut.rcon_q !== rcon_exp[i]) begin
          err_cnt++;
          $display("FAIL rcon_round%0d: got %h, want %h", i + 1, dut.rcon_q, rcon_exp[i]);
        end
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  // Reset at rk_index 5 aborts; a fresh key then expands correctly.
  task automatic test_reset_abort;
    bit hit = 1'b0;
    rk_ready = 1'b1;
    key_in   = key1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 20 && !hit; cyc++) begin
      if (rk_index === 4'd5) begin
        hit = 1'b1;
        rst = 1'b1;
      end
      @(negedge clk);
    end
    rst = 1'b0;
    cmp_cnt++;
    if (!hit || rk_valid !== 1'b0 || busy !== 1'b0 || rk_out !== 128'h0 || rk_index !== 4'd0) begin
      err_cnt++;
      $display("FAIL abort: hit=%b valid=%b busy=%b out=%h idx=%0d, want 1/0/0/0/0",
               hit, rk_valid, busy, rk_out, rk_index);
    end
    @(negedge clk);
    cmp_cnt++;
    if (rk_valid !== 1'b0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL abort_hold: valid=%b busy=%b, want 0/0", rk_valid, busy);
    end
    key_in = key2;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      if (i == 1) begin
        cmp_cnt++;
        if (rk_index !== 4'd1 || rk_out !== key2_rk1) begin
          err_cnt++;
          $display("FAIL key2_rk1: idx=%0d out=%h, want 1 %h", rk_index, rk_out, key2_rk1);
        end
      end
      if (i == 10) begin
        cmp_cnt++;
        if (rk_index !== 4'd10 || rk_out !== key2_rk10) begin
          err_cnt++;
          $display("FAIL key2_rk10: idx=%0d out=%h, want 10 %h", rk_index, rk_out, key2_rk10);
        end
      end
      @(negedge clk);
    end
    cmp_cnt++;
    if (done !== 1'b1) begin
      err_cnt++;
      $display("FAIL key2_done: done=%b, want 1", done);
    end
    @(negedge clk);
  endtask

`ifdef AES_KEYEXP_STORE_EN
  // Store still holds the key1 expansion from the preceding run.
  task automatic test_store;
    rd_idx = 4'd1;
    @(negedge clk);
    cmp_cnt++;
    if (rd_key !== exp1[1]) begin
      err_cnt++;
      $display("FAIL store_rd1: got %h, want %h", rd_key, exp1[1]);
    end
    rd_idx = 4'd10;
    @(negedge clk);
    cmp_cnt++;
    if (rd_key !== exp1[10]) begin
      err_cnt++;
      $display("FAIL store_rd10: got %h, want %h", rd_key, exp1[10]);
    end
    rd_idx = 4'd12;
    @(negedge clk);
    cmp_cnt++;
    if (rd_key !== 128'h0) begin
      err_cnt++;
      $display("FAIL store_rd12: got %h, want 0", rd_key);
    end
  endtask
`endif

  initial begin
    key1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    key2      = 128'h000102030405060708090a0b0c0d0e0f;
    key2_rk1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    key2_rk10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    exp1[0]   = key1;
    exp1[1]   = 128'ha0fafe1788542cb123a339392a6c7605;
    exp1[2]   = 128'hf2c295f27a96b9435935807a7359f67f;
    exp1[3]   = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp1[4]   = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp1[5]   = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp1[6]   = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp1[7]   = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp1[8]   = 128'head27321b58dbad2312bf5607f8d292f;
    exp1[9]   = 128'hac7766f319fadc2128d12941575c006e;
    exp1[10]  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    rcon_exp[0] = 8'h01; rcon_exp[1] = 8'h02; rcon_exp[2] = 8'h04; rcon_exp[3] = 8'h08;
    rcon_exp[4] = 8'h10; rcon_exp[5] = 8'h20; rcon_exp[6] = 8'h40; rcon_exp[7] = 8'h80;
    rcon_exp[8] = 8'h1b; rcon_exp[9] = 8'h36;

    rst      = 1'b1;
    start    = 1'b0;
    key_in   = '0;
    rk_ready = 1'b0;
`ifdef AES_KEYEXP_STORE_EN
    rd_idx   = 4'd0;
`endif

    test_reset();
    test_stream();
    test_stall();
    test_start_ignored();
    test_rcon();
`ifdef AES_KEYEXP_STORE_EN
    test_store();
`endif
    test_reset_abort();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
